alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational 64-bit ALU.
// A granted operation is launched into the ALU and its result is captured at
// the same edge into a single response slot (1-cycle accept-to-response).
// The slot is held stable until rsp_ready; a new grant may reload it in the
// acknowledging cycle, giving one operation per cycle under full throughput.
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests alternate, based on a last_grant register
//   undefined -> fixed priority, requester 0 always wins; no arbitration state
//                is kept in this build.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [3:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        req1_ready,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carryout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_r,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_carryout
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   slot_free_s;
  logic   grant_s;
  logic   win_s;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic   last_grant_r;
`endif

  // Response slot can take a new result when empty or being drained this cycle.
  always_comb begin
    slot_free_s = 1'b0;
    case (state_r)
      IDLE:    slot_free_s = 1'b1;
      HOLD:    slot_free_s = rsp_ready;
      default: slot_free_s = 1'b0;
    endcase
  end

  // Arbitration: at most one grant, never during reset or while backpressured.
  always_comb begin
    grant_s = 1'b0;
    win_s   = 1'b0;
    if (rst) begin
      grant_s = 1'b0;
      win_s   = 1'b0;
    end else if (slot_free_s) begin
      if (req0_valid && req1_valid) begin
        grant_s = 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        win_s   = ~last_grant_r;
`else
        win_s   = 1'b0;
`endif
      end else if (req0_valid) begin
        grant_s = 1'b1;
        win_s   = 1'b0;
      end else if (req1_valid) begin
        grant_s = 1'b1;
        win_s   = 1'b1;
      end else begin
        grant_s = 1'b0;
        win_s   = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
      win_s   = 1'b0;
    end
  end

  assign req0_ready = grant_s & ~win_s;
  assign req1_ready = grant_s & win_s;

  // Steer the winner's operands into the ALU; park it at zero when idle.
  always_comb begin
    alu_a  = 64'd0;
    alu_b  = 64'd0;
    alu_op = 4'b0000;
    if (grant_s) begin
      if (win_s) begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end else begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
    end else begin
      alu_a  = 64'd0;
      alu_b  = 64'd0;
      alu_op = 4'b0000;
    end
  end

  // Next-state: a grant always (re)fills the slot; a drain without grant empties it.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = IDLE;
        end
      end
      HOLD: begin
        if (grant_s) begin
          next_state_s = HOLD;
        end else if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register; reset discards any unacknowledged response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Response slot: capture ALU result and winner index at the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id       <= 1'b0;
      rsp_r        <= 64'd0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carryout <= 1'b0;
    end else if (grant_s) begin
      rsp_id       <= win_s;
      rsp_r        <= alu_r;
      rsp_zero     <= alu_zero;
      rsp_overflow <= alu_overflow;
      rsp_carryout <= alu_carryout;
    end else begin
      rsp_id       <= rsp_id;
      rsp_r        <= rsp_r;
      rsp_zero     <= rsp_zero;
      rsp_overflow <= rsp_overflow;
      rsp_carryout <= rsp_carryout;
    end
  end

  assign rsp_valid = (state_r == HOLD);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Remember the last winner so simultaneous requests alternate; reset favours req0 next.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (grant_s) begin
      last_grant_r <= win_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

endmodule
